mgmt_gpio_ctrl: RTL and testbench



---
 rtl/mgmt_gpio_ctrl.sv | 132 +++++++++++++
 tb/tb_mgmt_gpio_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_gpio_ctrl.sv
// Management GPIO controller: output/OEB registers toward the pad buffer, synchronized
// input edge capture with sticky W1C status and masked interrupt. Option: MGMT_GPIO_DEBOUNCE_EN.
module mgmt_gpio_ctrl #(
    parameter int NBITS   = 18,
    parameter int NOEB    = 3,
    parameter int DEB_DIV = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             reg_we,
    input  logic [2:0]       reg_addr,
    input  logic [NBITS-1:0] reg_wdata,
    output logic [NBITS-1:0] reg_rdata,
    input  logic [NBITS-1:0] mgmt_gpio_in_buf,
    output logic [NBITS-1:0] mgmt_gpio_out,
    output logic [NOEB-1:0]  mgmt_gpio_oeb,
    output logic             irq
);

    localparam logic [2:0] A_OUT    = 3'd0;
    localparam logic [2:0] A_OEB    = 3'd1;
    localparam logic [2:0] A_IN     = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_MASK   = 3'd4;
    localparam logic [2:0] A_POL    = 3'd5;

    logic [NBITS-1:0] r_out;
    logic [NOEB-1:0]  r_oeb;
    logic [NBITS-1:0] r_status;
    logic [NBITS-1:0] r_mask;
    logic [NBITS-1:0] r_pol;
    logic [NBITS-1:0] r_sync1;
    logic [NBITS-1:0] r_sync2;
    logic [NBITS-1:0] r_prev;
    logic [NBITS-1:0] r_rdata;
    logic             r_irq;

    logic [NBITS-1:0] w_in;
    logic [NBITS-1:0] w_edge;
    logic [NBITS-1:0] w_w1c;
    logic [NBITS-1:0] w_rd_mux;

`ifdef MGMT_GPIO_DEBOUNCE_EN
    localparam int CW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    logic [CW-1:0]    r_deb_cnt;
    logic [NBITS-1:0] r_d_a;
    logic [NBITS-1:0] r_d_b;
    logic [NBITS-1:0] r_d_hold;
    logic             w_tick;
    logic [NBITS-1:0] w_d_in;

    assign w_tick = (r_deb_cnt == CW'(DEB_DIV - 1));
    // Two agreeing tick samples pass straight through; otherwise the last agreed value holds.
    assign w_d_in = ((r_d_a ^ r_d_b) & r_d_hold) | (~(r_d_a ^ r_d_b) & r_d_a);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_deb_cnt <= '0;
            r_d_a     <= '0;
            r_d_b     <= '0;
            r_d_hold  <= '0;
        end else begin
            r_deb_cnt <= w_tick ? '0 : r_deb_cnt + 1'b1;
            r_d_hold  <= w_d_in;
            if (w_tick) begin
                r_d_a <= r_sync2;
                r_d_b <= r_d_a;
            end
        end
    end

    assign w_in = w_d_in;
`else
    assign w_in = r_sync2;
`endif

    // r_prev resets to the same value as the input path, so reset release never looks like an edge.
    assign w_edge = (r_pol & r_prev & ~w_in) | (~r_pol & ~r_prev & w_in);
    assign w_w1c  = (reg_we && reg_addr == A_STATUS) ? reg_wdata : '0;

    always_comb begin
        w_rd_mux = '0;
        case (reg_addr)
            A_OUT:    w_rd_mux = r_out;
            A_OEB:    w_rd_mux = {{(NBITS-NOEB){1'b0}}, r_oeb};
            A_IN:     w_rd_mux = w_in;
            A_STATUS: w_rd_mux = r_status;
            A_MASK:   w_rd_mux = r_mask;
            A_POL:    w_rd_mux = r_pol;
            default:  w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_out    <= '0;
            r_oeb    <= '1;
            r_status <= '0;
            r_mask   <= '0;
            r_pol    <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_sync1 <= mgmt_gpio_in_buf;
            r_sync2 <= r_sync1;
            r_prev  <= w_in;
            r_rdata <= w_rd_mux;
            // Clear first, then OR in new edges so a same-cycle edge survives its own W1C.
            r_status <= (r_status & ~w_w1c) | w_edge;
            r_irq    <= |(r_status & r_mask);
            if (reg_we) begin
                case (reg_addr)
                    A_OUT:   r_out  <= reg_wdata;
                    A_OEB:   r_oeb  <= reg_wdata[NOEB-1:0];
                    A_MASK:  r_mask <= reg_wdata;
                    A_POL:   r_pol  <= reg_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign reg_rdata     = r_rdata;
    assign mgmt_gpio_out = r_out;
    assign mgmt_gpio_oeb = r_oeb;
    assign irq           = r_irq;

endmodule

// File: tb/tb_mgmt_gpio_ctrl.sv
// Directed bench for mgmt_gpio_ctrl: register write/readback table plus edge, interrupt,
// W1C and reset sequences; the debounce sequence runs only with MGMT_GPIO_DEBOUNCE_EN.
module tb_mgmt_gpio_ctrl;

    localparam int NBITS = 18;
    localparam int NOEB  = 3;
`ifdef MGMT_GPIO_DEBOUNCE_EN
    localparam int SETTLE = 40;
`else
    localparam int SETTLE = 4;
`endif

    logic             wb_clk_i;
    logic             wb_rst_i;
    logic             reg_we;
    logic [2:0]       reg_addr;
    logic [NBITS-1:0] reg_wdata;
    logic [NBITS-1:0] reg_rdata;
    logic [NBITS-1:0] mgmt_gpio_in_buf;
    logic [NBITS-1:0] mgmt_gpio_out;
    logic [NOEB-1:0]  mgmt_gpio_oeb;
    logic             irq;

    int checks;
    int errors;

    typedef struct {
        logic [2:0]       addr;
        logic [NBITS-1:0] wdata;
        logic [NBITS-1:0] rexp;
        logic [NBITS-1:0] out_exp;
        logic [NOEB-1:0]  oeb_exp;
    } vec_t;

    vec_t vecs[14];

    mgmt_gpio_ctrl #(.NBITS(NBITS), .NOEB(NOEB), .DEB_DIV(16)) dut (
        .wb_clk_i         (wb_clk_i),
        .wb_rst_i         (wb_rst_i),
        .reg_we           (reg_we),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_rdata        (reg_rdata),
        .mgmt_gpio_in_buf (mgmt_gpio_in_buf),
        .mgmt_gpio_out    (mgmt_gpio_out),
        .mgmt_gpio_oeb    (mgmt_gpio_oeb),
        .irq              (irq)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // All driver tasks start and end just after a falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic wr(input logic [2:0] a, input logic [NBITS-1:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge wb_clk_i);
        reg_we    = 1'b0;
        reg_wdata = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [NBITS-1:0] v);
        reg_addr = a;
        @(negedge wb_clk_i);
        v = reg_rdata;
    endtask

    logic [NBITS-1:0] r;
    logic             found;

    initial begin
        checks = 0;
        errors = 0;
        wb_rst_i = 1'b0;
        reg_we = 1'b0;
        reg_addr = '0;
        reg_wdata = '0;
        mgmt_gpio_in_buf = '0;

        vecs[0]  = '{3'd0, 18'h2A5A5, 18'h2A5A5, 18'h2A5A5, 3'h7};
        vecs[1]  = '{3'd1, 18'h00002, 18'h00002, 18'h2A5A5, 3'h2};
        vecs[2]  = '{3'd1, 18'h3FFFF, 18'h00007, 18'h2A5A5, 3'h7};
        vecs[3]  = '{3'd0, 18'h15A5A, 18'h15A5A, 18'h15A5A, 3'h7};
        vecs[4]  = '{3'd4, 18'h15555, 18'h15555, 18'h15A5A, 3'h7};
        vecs[5]  = '{3'd5, 18'h0AAAA, 18'h0AAAA, 18'h15A5A, 3'h7};
        vecs[6]  = '{3'd6, 18'h3FFFF, 18'h00000, 18'h15A5A, 3'h7};
        vecs[7]  = '{3'd7, 18'h12345, 18'h00000, 18'h15A5A, 3'h7};
        vecs[8]  = '{3'd3, 18'h3FFFF, 18'h00000, 18'h15A5A, 3'h7};
        vecs[9]  = '{3'd2, 18'h3FFFF, 18'h00000, 18'h15A5A, 3'h7};
        vecs[10] = '{3'd4, 18'h00000, 18'h00000, 18'h15A5A, 3'h7};
        vecs[11] = '{3'd5, 18'h00000, 18'h00000, 18'h15A5A, 3'h7};
        vecs[12] = '{3'd1, 18'h00002, 18'h00002, 18'h15A5A, 3'h2};
        vecs[13] = '{3'd0, 18'h2A5A5, 18'h2A5A5, 18'h2A5A5, 3'h2};

        // Reset state
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        cyc(2);
        check("rst_oeb", 18'(mgmt_gpio_oeb), 18'h7);
        check("rst_out", mgmt_gpio_out, 18'h0);
        check("rst_irq", 18'(irq), 18'h0);
        wb_rst_i = 1'b0;
        for (int a = 0; a < 6; a++) begin
            rd(3'(a), r);
            check($sformatf("rst_read_a%0d", a), r, (a == 1) ? 18'h7 : 18'h0);
        end

        // Register write / readback table
        for (int i = 0; i < 14; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_out", i), mgmt_gpio_out, vecs[i].out_exp);
            check($sformatf("vec%0d_oeb", i), 18'(mgmt_gpio_oeb), 18'(vecs[i].oeb_exp));
            rd(vecs[i].addr, r);
            check($sformatf("vec%0d_read", i), r, vecs[i].rexp);
        end

        // IN register and multi-bit rising capture
        mgmt_gpio_in_buf = 18'h2A040;
        cyc(SETTLE);
        rd(3'd2, r);
        check("in_read", r, 18'h2A040);
        rd(3'd3, r);
        check("multi_rise_status", r, 18'h2A040);
        wr(3'd3, 18'h3FFFF);
        rd(3'd3, r);
        check("multi_w1c", r, 18'h0);

        // Rising edge on bit 0 with interrupt enabled
        wr(3'd4, 18'h00001);
        wr(3'd5, 18'h00000);
        reg_addr = 3'd3;
        mgmt_gpio_in_buf[0] = 1'b1;
`ifndef MGMT_GPIO_DEBOUNCE_EN
        cyc(3);
        check("rise_irq_c3", 18'(irq), 18'h0);
        check("rise_status_before", reg_rdata, 18'h0);
        cyc(1);
        check("rise_irq_c4", 18'(irq), 18'h1);
        check("rise_status_c3", reg_rdata, 18'h1);
`else
        cyc(SETTLE);
        check("rise_irq", 18'(irq), 18'h1);
`endif
        wr(3'd3, 18'h00001);
        cyc(1);
        check("w1c_irq_clear", 18'(irq), 18'h0);
        rd(3'd3, r);
        check("w1c_status_clear", r, 18'h0);

        // Falling edge on bit 5, masked
        wr(3'd4, 18'h00000);
        wr(3'd5, 18'h00020);
        mgmt_gpio_in_buf[5] = 1'b1;
        cyc(SETTLE);
        rd(3'd3, r);
        check("fall_pol_ignores_rise", r, 18'h0);
        mgmt_gpio_in_buf[5] = 1'b0;
        cyc(SETTLE);
        rd(3'd3, r);
        check("fall_status", r, 18'h00020);
        check("fall_masked_irq", 18'(irq), 18'h0);
        wr(3'd3, 18'h00020);
        mgmt_gpio_in_buf[5] = 1'b1;
        cyc(SETTLE);
        rd(3'd3, r);
        check("fall_rise_again", r, 18'h0);

        // POL change with a steady high input must not create an edge
        wr(3'd5, 18'h00021);
        cyc(3);
        rd(3'd3, r);
        check("pol_change_only", r, 18'h0);

        // Edge on bit 3 in the same cycle as its W1C; set wins
        mgmt_gpio_in_buf[3] = 1'b1;
`ifndef MGMT_GPIO_DEBOUNCE_EN
        cyc(2);
        wr(3'd3, 18'h00008);
        rd(3'd3, r);
        check("set_beats_clear", r, 18'h00008);
`else
        cyc(SETTLE);
        rd(3'd3, r);
        check("bit3_status", r, 18'h00008);
`endif
        wr(3'd3, 18'h00001);
        rd(3'd3, r);
        check("w1c_zero_bits_keep", r, 18'h00008);
        check("bit3_masked_irq", 18'(irq), 18'h0);
        wr(3'd4, 18'h00008);
        cyc(2);
        check("bit3_unmasked_irq", 18'(irq), 18'h1);
        wr(3'd3, 18'h00008);
        rd(3'd3, r);
        check("bit3_clear", r, 18'h0);

        // Reset mid-operation with the synchronizers still holding ones
        wr(3'd4, 18'h3FFFF);
        wr(3'd5, 18'h3FFFF);
        wb_rst_i = 1'b1;
        mgmt_gpio_in_buf = '0;
        cyc(2);
        wb_rst_i = 1'b0;
        cyc(SETTLE + 2);
        check("midrst_out", mgmt_gpio_out, 18'h0);
        check("midrst_oeb", 18'(mgmt_gpio_oeb), 18'h7);
        check("midrst_irq", 18'(irq), 18'h0);
        rd(3'd3, r);
        check("midrst_status", r, 18'h0);
        rd(3'd4, r);
        check("midrst_mask", r, 18'h0);
        rd(3'd5, r);
        check("midrst_pol", r, 18'h0);

`ifdef MGMT_GPIO_DEBOUNCE_EN
        // Short glitch never reported; long level reported within 35 cycles of the rise
        mgmt_gpio_in_buf[7] = 1'b1;
        cyc(5);
        mgmt_gpio_in_buf[7] = 1'b0;
        cyc(50);
        rd(3'd3, r);
        check("deb_glitch", r, 18'h0);
        reg_addr = 3'd3;
        mgmt_gpio_in_buf[7] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 36 && !found; k++) begin
            @(negedge wb_clk_i);
            if (reg_rdata[7]) found = 1'b1;
        end
        check("deb_level_seen", 18'(found), 18'h1);
        cyc(5);
        mgmt_gpio_in_buf[7] = 1'b0;
`else
        found = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
